hi_fanout_tree: RTL and testbench

HI_FANOUT_TREE -- requirements
Module: hi_fanout_tree

---
 rtl/hi_fanout_pkg.sv | 45 ++++
 rtl/fanout_reduce.sv | 29 ++
 rtl/hi_fanout_tree.sv | 94 +++++++++
 tb/tb_hi_fanout_tree.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_fanout_pkg.sv
// Shared types and elaboration-time helpers for the high-fanout replication tree.
package hi_fanout_pkg;

  typedef enum int {
    RED_NAND = 0,
    RED_AND  = 1,
    RED_OR   = 2,
    RED_XOR  = 3
  } reduce_mode_e;

  localparam int MAX_ITER = 32;

  function automatic int ceil_log(input int n, input int base);
    longint p;
    int     r;
    p = 1;
    r = 0;
    for (int i = 0; i < MAX_ITER; i++) begin
      if (p < longint'(n)) begin
        p = p * longint'(base);
        r = r + 1;
      end
    end
    return r;
  endfunction

  function automatic int calc_stages(input int n, input int fanout);
    int s;
    s = ceil_log(n, fanout);
    return (s < 1) ? 1 : s;
  endfunction

  // Copies held by replication stage 'stage' (1-based): ceil(n / fanout^(STAGES-stage)).
  function automatic int calc_copies(input int n, input int fanout, input int stage);
    longint pw;
    int     st;
    st = calc_stages(n, fanout);
    pw = 1;
    for (int i = 0; i < MAX_ITER; i++) begin
      if (i < st - stage) pw = pw * longint'(fanout);
    end
    return int'((longint'(n) + pw - 1) / pw);
  endfunction

endpackage

// File: rtl/fanout_reduce.sv
// Combinational NUM_IN-input bitwise reduction gate (NAND/AND/OR/XOR).
module fanout_reduce
  import hi_fanout_pkg::*;
#(
  parameter int NUM_IN      = 2,
  parameter int DATA_W      = 1,
  parameter int REDUCE_MODE = 0
) (
  input  logic [NUM_IN*DATA_W-1:0] din,
  output logic [DATA_W-1:0]        dout
);

  localparam reduce_mode_e MODE = reduce_mode_e'(REDUCE_MODE);

  logic [DATA_W-1:0] acc;

  always_comb begin
    acc = din[DATA_W-1:0];
    for (int i = 1; i < NUM_IN; i++) begin
      case (MODE)
        RED_OR:  acc = acc | din[i*DATA_W +: DATA_W];
        RED_XOR: acc = acc ^ din[i*DATA_W +: DATA_W];
        default: acc = acc & din[i*DATA_W +: DATA_W];
      endcase
    end
    dout = (MODE == RED_NAND) ? ~acc : acc;
  end

endmodule

// File: rtl/hi_fanout_tree.sv
// Driver regs -> reduction gate -> STAGES replication stages -> NUM_LOADS load regs.
// Fixed latency STAGES+2; hold freezes every register, no backpressure otherwise.
module hi_fanout_tree
  import hi_fanout_pkg::*;
#(
  parameter int NUM_IN      = 2,
  parameter int DATA_W      = 1,
  parameter int NUM_LOADS   = 150,
  parameter int FANOUT      = 16,
  parameter int REDUCE_MODE = 0
) (
  input  logic                        clk1,
  input  logic                        rst,
  input  logic [NUM_IN*DATA_W-1:0]    data,
  input  logic                        in_valid,
  input  logic                        hold,
  output logic [NUM_LOADS*DATA_W-1:0] outputs,
  output logic                        out_valid,
  output logic                        busy
);

  localparam int STAGES = calc_stages(NUM_LOADS, FANOUT);
  localparam int VLD_W  = STAGES + 2;

  logic [NUM_IN*DATA_W-1:0]    drv_q, drv_d;
  logic [DATA_W-1:0]           reduced;
  logic [NUM_LOADS*DATA_W-1:0] load_src;
  logic [NUM_LOADS*DATA_W-1:0] load_q, load_d;
  logic [VLD_W-1:0]            vld_q, vld_d;

  fanout_reduce #(
    .NUM_IN      (NUM_IN),
    .DATA_W      (DATA_W),
    .REDUCE_MODE (REDUCE_MODE)
  ) u_reduce (
    .din  (drv_q),
    .dout (reduced)
  );

  // Each copy in stage s is fed by copy floor(c/FANOUT) of stage s-1.
  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    localparam int NC = calc_copies(NUM_LOADS, FANOUT, s);

    (* keep = "true", dont_touch = "true" *) logic [DATA_W-1:0] rep_q [NC];
    logic [DATA_W-1:0] rep_d [NC];
    logic [DATA_W-1:0] src   [NC];

    for (genvar c = 0; c < NC; c++) begin : g_copy
      if (s == 1) begin : g_src
        assign src[c] = reduced;
      end else begin : g_src
        assign src[c] = g_stage[s-1].rep_q[c / FANOUT];
      end
    end

    always_comb begin
      for (int c = 0; c < NC; c++) begin
        rep_d[c] = hold ? rep_q[c] : src[c];
      end
    end

    always_ff @(posedge clk1 or posedge rst) begin
      if (rst) rep_q <= '{default: '0};
      else     rep_q <= rep_d;
    end
  end

  for (genvar k = 0; k < NUM_LOADS; k++) begin : g_load
    assign load_src[k*DATA_W +: DATA_W] = g_stage[STAGES].rep_q[k / FANOUT];
  end

  always_comb begin
    drv_d  = hold ? drv_q  : data;
    load_d = hold ? load_q : load_src;
    vld_d  = hold ? vld_q  : {vld_q[VLD_W-2:0], in_valid};
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      drv_q  <= '0;
      load_q <= '0;
      vld_q  <= '0;
    end else begin
      drv_q  <= drv_d;
      load_q <= load_d;
      vld_q  <= vld_d;
    end
  end

  assign outputs   = load_q;
  assign out_valid = vld_q[VLD_W-1];
  assign busy      = |vld_q[VLD_W-2:0];

endmodule

// File: tb/tb_hi_fanout_tree.sv
// Directed and random checks of hi_fanout_tree across four parameter sets.
module tb_hi_fanout_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // d: defaults (NAND, 2x1, 150 loads, fanout 16) latency 4
  logic [1:0]    d_data;
  logic          d_vld, d_hold, d_ov, d_busy;
  logic [149:0]  d_out;
  // x: XOR, 4x8, 150 loads, fanout 16, latency 4
  logic [31:0]   x_data;
  logic          x_vld, x_hold, x_ov, x_busy;
  logic [1199:0] x_out;
  // r: OR, 2x4, 37 loads, fanout 8, latency 4
  logic [7:0]    r_data;
  logic          r_vld, r_hold, r_ov, r_busy;
  logic [147:0]  r_out;
  // a: AND, 3x2, 5 loads, fanout 2, STAGES=3, latency 5
  logic [5:0]    a_data;
  logic          a_vld, a_hold, a_ov, a_busy;
  logic [9:0]    a_out;

  hi_fanout_tree u_d (
    .clk1(clk), .rst(rst), .data(d_data), .in_valid(d_vld), .hold(d_hold),
    .outputs(d_out), .out_valid(d_ov), .busy(d_busy)
  );

  hi_fanout_tree #(.NUM_IN(4), .DATA_W(8), .NUM_LOADS(150), .FANOUT(16), .REDUCE_MODE(3)) u_x (
    .clk1(clk), .rst(rst), .data(x_data), .in_valid(x_vld), .hold(x_hold),
    .outputs(x_out), .out_valid(x_ov), .busy(x_busy)
  );

  hi_fanout_tree #(.NUM_IN(2), .DATA_W(4), .NUM_LOADS(37), .FANOUT(8), .REDUCE_MODE(2)) u_r (
    .clk1(clk), .rst(rst), .data(r_data), .in_valid(r_vld), .hold(r_hold),
    .outputs(r_out), .out_valid(r_ov), .busy(r_busy)
  );

  hi_fanout_tree #(.NUM_IN(3), .DATA_W(2), .NUM_LOADS(5), .FANOUT(2), .REDUCE_MODE(1)) u_a (
    .clk1(clk), .rst(rst), .data(a_data), .in_valid(a_vld), .hold(a_hold),
    .outputs(a_out), .out_valid(a_ov), .busy(a_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chkv(input string name, input logic [1199:0] act, input logic [1199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (low 256 bits)", name, act[255:0], exp[255:0]);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        tgt;   // 0 = default instance, 1 = XOR instance
    logic [31:0] din;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t tbl [7];

  logic [3:0] hr  [0:1000];
  logic       hrv [0:1000];
  logic [1:0] ha  [0:1000];
  logic       hav [0:1000];

  initial begin
    int ovs;
    int ir;
    int ia;

    tbl[0] = '{1'b0, 32'h0000_0003, 8'h00, "nand_11"};
    tbl[1] = '{1'b0, 32'h0000_0001, 8'h01, "nand_01"};
    tbl[2] = '{1'b0, 32'h0000_0002, 8'h01, "nand_10"};
    tbl[3] = '{1'b1, 32'h01FF_F00F, 8'h01, "xor_0f_f0_ff_01"};
    tbl[4] = '{1'b1, 32'h0000_55AA, 8'hFF, "xor_aa_55"};
    tbl[5] = '{1'b1, 32'h7856_3412, 8'h08, "xor_12_34_56_78"};
    tbl[6] = '{1'b0, 32'h0000_0000, 8'h01, "nand_00"};

    rst = 1'b1;
    d_data = '0; d_vld = 1'b0; d_hold = 1'b0;
    x_data = '0; x_vld = 1'b0; x_hold = 1'b0;
    r_data = '0; r_vld = 1'b0; r_hold = 1'b0;
    a_data = '0; a_vld = 1'b0; a_hold = 1'b0;

    #12;
    chkv("reset_outputs_nand", 1200'(d_out), 1200'(0));
    chk1("reset_out_valid", d_ov, 1'b0);
    chk1("reset_busy", d_busy, 1'b0);
    chkv("reset_outputs_xor", x_out, 1200'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Single tokens, latency 4
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].tgt == 1'b0) begin
        d_data = tbl[i].din[1:0];
        d_vld  = 1'b1;
      end else begin
        x_data = tbl[i].din;
        x_vld  = 1'b1;
      end
      tick();
      d_vld = 1'b0;
      x_vld = 1'b0;
      repeat (3) tick();
      if (tbl[i].tgt == 1'b0) begin
        chkv({tbl[i].name, "_out"}, 1200'(d_out), 1200'({150{tbl[i].exp[0]}}));
        chk1({tbl[i].name, "_ov"}, d_ov, 1'b1);
        chk1({tbl[i].name, "_busy"}, d_busy, 1'b0);
        tick();
        chk1({tbl[i].name, "_ov_pulse_end"}, d_ov, 1'b0);
      end else begin
        chkv({tbl[i].name, "_out"}, x_out, {150{tbl[i].exp}});
        chk1({tbl[i].name, "_ov"}, x_ov, 1'b1);
        chk1({tbl[i].name, "_busy"}, x_busy, 1'b0);
        tick();
        chk1({tbl[i].name, "_ov_pulse_end"}, x_ov, 1'b0);
      end
    end

    // Asynchronous reset with three tokens in flight
    d_data = 2'b00;
    d_vld  = 1'b1;
    repeat (3) tick();
    d_vld = 1'b0;
    chk1("inflight_busy", d_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chkv("async_rst_outputs", 1200'(d_out), 1200'(0));
    chk1("async_rst_ov", d_ov, 1'b0);
    chk1("async_rst_busy", d_busy, 1'b0);
    #2 rst = 1'b0;
    tick();
    tick();
    chkv("post_rst_out_e2", 1200'(d_out), 1200'(0));
    tick();
    chkv("post_rst_out_e3", 1200'(d_out), 1200'({150{1'b1}}));
    ovs = 0;
    repeat (5) begin
      tick();
      ovs += int'(d_ov);
    end
    chkv("no_stale_token", 1200'(ovs), 1200'(0));
    d_data = 2'b11;
    d_vld  = 1'b1;
    tick();
    d_vld = 1'b0;
    tick();
    tick();
    chk1("first_token_e3_ov", d_ov, 1'b0);
    tick();
    chk1("first_token_e4_ov", d_ov, 1'b1);
    chkv("first_token_e4_out", 1200'(d_out), 1200'(0));
    repeat (4) tick();

    // Back-to-back tokens every cycle
    d_data = 2'b01;
    d_vld  = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk1("b2b_busy", d_busy, 1'b1);
      if (n >= 4) begin
        chk1("b2b_ov_high", d_ov, 1'b1);
        chkv("b2b_out", 1200'(d_out), 1200'({150{1'b1}}));
      end else begin
        chk1("b2b_ov_fill", d_ov, 1'b0);
      end
    end
    d_vld = 1'b0;

    // Hold for 5 cycles mid-stream; the token offered during hold is dropped
    x_data = '0;
    x_vld  = 1'b0;
    repeat (5) tick();
    x_data = 32'h11; x_vld = 1'b1;
    tick();
    x_data = 32'h22;
    tick();
    x_hold = 1'b1;
    x_data = 32'h99;
    repeat (5) begin
      tick();
      chkv("hold_out_frozen", x_out, 1200'(0));
      chk1("hold_ov_frozen", x_ov, 1'b0);
      chk1("hold_busy_frozen", x_busy, 1'b1);
    end
    x_hold = 1'b0;
    x_vld  = 1'b0;
    x_data = '0;
    tick();
    chkv("release_e1_out", x_out, 1200'(0));
    chk1("release_e1_ov", x_ov, 1'b0);
    tick();
    chkv("release_tokA_out", x_out, {150{8'h11}});
    chk1("release_tokA_ov", x_ov, 1'b1);
    tick();
    chkv("release_tokB_out", x_out, {150{8'h22}});
    chk1("release_tokB_ov", x_ov, 1'b1);
    chk1("release_tokB_busy", x_busy, 1'b0);
    tick();
    chkv("release_drain_out", x_out, 1200'(0));
    chk1("release_drain_ov", x_ov, 1'b0);
    ovs = 0;
    repeat (4) begin
      tick();
      ovs += int'(x_ov);
    end
    chkv("hold_token_dropped", 1200'(ovs), 1200'(0));

    // Random vectors against a delay-line reference
    tick();
    rst = 1'b1;
    #2 rst = 1'b0;
    hr[0] = '0; hrv[0] = 1'b0; ha[0] = '0; hav[0] = 1'b0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      r_data = 8'($urandom);
      r_vld  = 1'($urandom_range(0, 1));
      a_data = 6'($urandom);
      a_vld  = 1'($urandom_range(0, 1));
      hr[cyc]  = r_data[3:0] | r_data[7:4];
      hrv[cyc] = r_vld;
      ha[cyc]  = a_data[1:0] & a_data[3:2] & a_data[5:4];
      hav[cyc] = a_vld;
      tick();
      ir = (cyc >= 4) ? cyc - 3 : 0;
      ia = (cyc >= 5) ? cyc - 4 : 0;
      chkv("rnd37_out", 1200'(r_out), 1200'({37{hr[ir]}}));
      chk1("rnd37_ov", r_ov, hrv[ir]);
      chkv("rnd5_and_out", 1200'(a_out), 1200'({5{ha[ia]}}));
      chk1("rnd5_and_ov", a_ov, hav[ia]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
